// File: rtl/ps2_host_tx_pkg.sv
// Purpose: shared PS/2 host-transmit definitions (state encoding, command bytes, frame helper).
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package ps2_defs;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t INHIBIT   = 3'd1;
  localparam state_t RTS       = 3'd2;
  localparam state_t SHIFT     = 3'd3;
  localparam state_t ACK       = 3'd4;
  localparam state_t WAIT_IDLE = 3'd5;
  localparam state_t ERR       = 3'd6;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // Nine bits shifted out LSB first: data byte then odd parity.
  function automatic logic [8:0] ps2_frame(input logic [7:0] d);
    return {~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Purpose: 2-flop synchroniser + FILTER_LEN-deep glitch filter + falling-edge pulse for one PS/2 line.
// Latency: pad edge to fall_o pulse is FILTER_LEN+2 cycles; level_o follows one cycle later.
// Backpressure: none, samples every cycle.
// Ports: clk_i/rst_i (async active-high), pad_i raw pad level, level_o filtered level,
//        fall_o one-cycle pulse on a filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] taps_q;
  logic                  level_q;
  logic                  level_d;

  // Idle PS/2 lines are high, so everything resets to 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      taps_q  <= '1;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], pad_i};
      taps_q  <= {taps_q[FILTER_LEN-2:0], sync_q[1]};
      level_q <= level_d;
    end
  end

  // Level only moves when every tap agrees; anything shorter is a glitch.
  always_comb begin
    level_d = level_q;
    if (&taps_q) begin
      level_d = 1'b1;
    end else if (~|taps_q) begin
      level_d = 1'b0;
    end
  end

  assign level_o = level_q;
  // Pulse in the cycle the taps first all read 0, ahead of the level update.
  assign fall_o  = level_q & ~level_d;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device byte transmitter (request-to-send, 8 data + odd parity + stop, ACK check).
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by the device clock (11 falls) plus line-idle wait.
// Backpressure: iSend accepted only while oBusy=0; strobes while busy are dropped, no queueing.
// Ports: Clock/Reset (async active-high); iData/iSend command request; oBusy/oDone/oError status;
//        PS2_CLK_IN/PS2_DATA_IN raw pads; oClkOE/oDataOE open-drain pull-low enables.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iSend,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       oClkOE,
  output logic       oDataOE
);

  // INHIBIT lasts INHIBIT_CYCLES-1 cycles and RTS one more, both holding the clock low.
  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 2);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [8:0]  shift_q, shift_d;
  logic [3:0]  count_q, count_d;
  logic [19:0] timer_q, timer_d;
  logic        data_oe_q, data_oe_d;

  logic clk_lvl, clk_fall, data_lvl;
  logic timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .pad_i   (PS2_CLK_IN),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .pad_i   (PS2_DATA_IN),
    .level_o (data_lvl),
    .fall_o  ()
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      data_oe_q <= data_oe_d;
    end
  end

  // A device clock fall always restarts the watchdog, so it can never time out on that cycle.
  assign timeout = ~clk_fall && (timer_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    timer_d   = timer_q;
    data_oe_d = data_oe_q;
    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (iSend) begin
          shift_d = ps2_frame(iData);
          count_d = '0;
          timer_d = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        timer_d = timer_q + 20'd1;
        if (timer_q == INH_LAST) begin
          data_oe_d = 1'b1;  // start bit, asserted while the clock is still held
          state_d   = RTS;
        end
      end
      RTS: begin
        timer_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        timer_d = clk_fall ? '0 : timer_q + 20'd1;
        if (timeout) begin
          state_d = ERR;
        end else if (clk_fall) begin
          if (count_q == 4'd9) begin
            data_oe_d = 1'b0;  // stop bit is the released line
            count_d   = '0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            count_d   = count_q + 4'd1;
          end
        end
      end
      ACK: begin
        timer_d = clk_fall ? '0 : timer_q + 20'd1;
        if (timeout) begin
          state_d = ERR;
        end else if (clk_fall) begin
          state_d = data_lvl ? ERR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        timer_d = clk_fall ? '0 : timer_q + 20'd1;
        if (clk_lvl && data_lvl) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Every error path drops the data line on entry so ERR drives nothing.
    if (state_d == ERR || state_d == IDLE) begin
      data_oe_d = 1'b0;
    end
  end

  always_comb begin
    oClkOE = 1'b0;
    oBusy  = 1'b0;
    oDone  = 1'b0;
    oError = 1'b0;
    if (state_q == INHIBIT || state_q == RTS) begin
      oClkOE = 1'b1;
    end
    if (state_q != IDLE) begin
      oBusy = 1'b1;
    end
    if (state_q == WAIT_IDLE && clk_lvl && data_lvl) begin
      oDone = 1'b1;
    end
    if (state_q == ERR) begin
      oError = 1'b1;
    end
  end

  assign oDataOE = data_oe_q;

endmodule
